// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Per-core stall/flush sequencer for the 5-stage pipeline registers and PC.
// Every cycle it chooses which stages advance, hold or take a bubble. The
// inputs are the cache handshakes, load-use hazards, EX-stage redirects and
// halt. It holds the memory-wait and halt-drain state machine.
//
// Ports
//   CLK, nRST                  clock, asynchronous active-low reset
//   ihit, dhit                 icache / dcache completion handshakes
//   dREN_mem, dWEN_mem         MEM stage load / store
//   dREN_ex, Rt_ex             EX stage load and its destination register
//   Rs_id, Rt_id               ID stage source registers
//   redirect_ex, halt_ex       EX stage control redirect / halt
//   pc_enable                  PC register load
//   enable_* / flush_*         pipeline register controls (flush wins)
//   halt                       sticky core-halted flag
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   stall_cycles, flush_events saturating performance counters [CNT_W]
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             dREN_ex,
    input  logic [4:0]       Rt_ex,
    input  logic [4:0]       Rs_id,
    input  logic [4:0]       Rt_id,
    input  logic             redirect_ex,
    input  logic             halt_ex,
    output logic             pc_enable,
    output logic             enable_ifid,
    output logic             flush_ifid,
    output logic             enable_idex,
    output logic             flush_idex,
    output logic             enable_exmem,
    output logic             flush_exmem,
    output logic             enable_memwb,
    output logic             flush_memwb,
    output logic             halt
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    // Control vector order:
    // {pc, en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, fl_exmem, en_memwb, fl_memwb}
    localparam logic [8:0] V_IDLE  = 9'b000000000;
    localparam logic [8:0] V_STALL = 9'b000000001;  // freeze all, bubble into MEM/WB
    localparam logic [8:0] V_HOLD  = 9'b000111010;  // hold PC+IF/ID, bubble into ID/EX
    localparam logic [8:0] V_REDIR = 9'b111111010;  // load target, squash IF/ID and ID/EX
    localparam logic [8:0] V_MISS  = 9'b011101010;  // hold PC, bubble into IF/ID
    localparam logic [8:0] V_RUN   = 9'b110101010;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [8:0]    ctrl_s;
    logic [8:0]    rule_vec_s;
    logic          rule_drain_s;
    logic          rule_redirect_s;
    logic          redirect_taken_s;
    logic          halt_s;
    logic          mem_stall_s;

    function automatic logic load_use_f(input logic       ren,
                                        input logic [4:0] rt,
                                        input logic [4:0] rs_src,
                                        input logic [4:0] rt_src);
        return ren & (rt != 5'd0) & ((rt == rs_src) | (rt == rt_src));
    endfunction

    assign mem_stall_s = (dREN_mem | dWEN_mem) & ~dhit;

    // Priority-ordered hazard rules used once no memory stall is pending.
    always_comb begin
        rule_vec_s      = V_RUN;
        rule_drain_s    = 1'b0;
        rule_redirect_s = 1'b0;
        if (halt_ex) begin
            rule_vec_s   = V_HOLD;
            rule_drain_s = 1'b1;
        end else if (redirect_ex) begin
            // Redirect overrides both the load-use hold and a pending fetch
            // because the younger instructions are squashed anyway.
            rule_vec_s      = V_REDIR;
            rule_redirect_s = 1'b1;
        end else if (load_use_f(dREN_ex, Rt_ex, Rs_id, Rt_id)) begin
            rule_vec_s = V_HOLD;
        end else if (!ihit) begin
            rule_vec_s = V_MISS;
        end else begin
            rule_vec_s = V_RUN;
        end
    end

    // Next-state, drain counter and pipeline control decode.
    always_comb begin
        ctrl_s           = V_IDLE;
        halt_s           = 1'b0;
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        redirect_taken_s = 1'b0;
        if (!nRST) begin
            // Outputs stay at reset values while reset is asserted.
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_stall_s) begin
                        ctrl_s      = V_STALL;
                        state_nxt_s = ST_MEM_WAIT;
                    end else begin
                        ctrl_s           = rule_vec_s;
                        redirect_taken_s = rule_redirect_s;
                        state_nxt_s      = rule_drain_s ? ST_DRAIN : ST_RUN;
                        cnt_nxt_s        = rule_drain_s ? CW'(DRAIN_CYCLES - 1) : cnt_r;
                    end
                end
                ST_MEM_WAIT: begin
                    // Only dhit releases the wait, even if memreq drops.
                    if (!dhit) begin
                        ctrl_s = V_STALL;
                    end else begin
                        ctrl_s           = rule_vec_s;
                        redirect_taken_s = rule_redirect_s;
                        state_nxt_s      = rule_drain_s ? ST_DRAIN : ST_RUN;
                        cnt_nxt_s        = rule_drain_s ? CW'(DRAIN_CYCLES - 1) : cnt_r;
                    end
                end
                ST_DRAIN: begin
                    if (mem_stall_s) begin
                        ctrl_s = V_STALL;
                    end else begin
                        ctrl_s = V_HOLD;
                        if (cnt_r == CW'(0)) begin
                            state_nxt_s = ST_HALTED;
                        end else begin
                            cnt_nxt_s = cnt_r - CW'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    halt_s = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    assign {pc_enable, enable_ifid, flush_ifid, enable_idex, flush_idex,
            enable_exmem, flush_exmem, enable_memwb, flush_memwb} = ctrl_s;
    assign halt = halt_s;

    // State and drain counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_RUN;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stall_inc_s;

    assign stall_inc_s = ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) && !ctrl_s[8];

    // Saturating stall-cycle and redirect-flush counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= {CNT_W{1'b0}};
            flush_events <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (redirect_taken_s && (flush_events != {CNT_W{1'b1}})) begin
                flush_events <= flush_events + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_events <= flush_events;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed and randomized stimulus for pipeline_hazard_ctrl. The expected
// values come from a behavioural model of the controller's rules. That model
// keeps a mode and a count of remaining drain cycles.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 2;
    localparam int CNT_W = 32;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, redirect_ex, halt_ex;
    logic [4:0] Rt_ex, Rs_id, Rt_id;
    logic       pc_enable, enable_ifid, flush_ifid, enable_idex, flush_idex;
    logic       enable_exmem, flush_exmem, enable_memwb, flush_memwb, halt;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_events;
    int               m_stalls, m_flushes;
`endif

    int checks = 0;
    int errors = 0;

    // model: 0 = running, 1 = waiting on dcache, 2 = draining, 3 = halted
    int m_mode;
    int m_left;
    int halted_for;
    bit m_redir;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
        .Rt_ex(Rt_ex), .Rs_id(Rs_id), .Rt_id(Rt_id),
        .redirect_ex(redirect_ex), .halt_ex(halt_ex),
        .pc_enable(pc_enable), .enable_ifid(enable_ifid), .flush_ifid(flush_ifid),
        .enable_idex(enable_idex), .flush_idex(flush_idex),
        .enable_exmem(enable_exmem), .flush_exmem(flush_exmem),
        .enable_memwb(enable_memwb), .flush_memwb(flush_memwb), .halt(halt)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [9:0] pack(input bit pc, input bit eif, input bit fif,
                                        input bit eid, input bit fid, input bit eex,
                                        input bit emw, input bit fmw, input bit hlt);
        return {pc, eif, fif, eid, fid, eex, 1'b0, emw, fmw, hlt};
    endfunction

    function automatic logic [9:0] observed();
        return {pc_enable, enable_ifid, flush_ifid, enable_idex, flush_idex,
                enable_exmem, flush_exmem, enable_memwb, flush_memwb, halt};
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected controls for the current model mode and inputs.
    function automatic logic [9:0] expected();
        bit memreq, lu, stall;
        m_redir = 1'b0;
        memreq  = dREN_mem | dWEN_mem;
        lu      = dREN_ex && Rt_ex != 0 && (Rt_ex == Rs_id || Rt_ex == Rt_id);
        if (m_mode == 3) return pack(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stall = (m_mode == 1) ? !dhit : (memreq && !dhit);
        if (stall)            return pack(0, 0, 0, 0, 0, 0, 0, 1, 0);
        if (m_mode == 2)      return pack(0, 0, 0, 1, 1, 1, 1, 0, 0);
        if (halt_ex)          return pack(0, 0, 0, 1, 1, 1, 1, 0, 0);
        if (redirect_ex) begin
            m_redir = 1'b1;
            return pack(1, 1, 1, 1, 1, 1, 1, 0, 0);
        end
        if (lu)               return pack(0, 0, 0, 1, 1, 1, 1, 0, 0);
        if (!ihit)            return pack(0, 1, 1, 1, 0, 1, 1, 0, 0);
        return pack(1, 1, 0, 1, 0, 1, 1, 0, 0);
    endfunction

    // Advance the model by one clock edge.
    task automatic model_step();
        bit memreq;
        memreq = dREN_mem | dWEN_mem;
        case (m_mode)
            0, 1: begin
                if ((m_mode == 0 && memreq && !dhit) || (m_mode == 1 && !dhit)) m_mode = 1;
                else if (halt_ex) begin m_mode = 2; m_left = DRAIN; end
                else m_mode = 0;
            end
            2: begin
                if (!(memreq && !dhit)) begin
                    m_left--;
                    if (m_left == 0) m_mode = 3;
                end
            end
            default: m_mode = 3;
        endcase
        halted_for = (m_mode == 3) ? halted_for + 1 : 0;
    endtask

    // One cycle: compare at the falling edge, then step model at the rising edge.
    task automatic cyc(input string tag);
        logic [9:0] e;
        @(negedge CLK);
        e = expected();
        check(tag, observed(), e);
`ifdef HAZARD_PERF_CNT_EN
        if ((m_mode == 0 || m_mode == 1) && !e[9]) m_stalls++;
        if (m_redir) m_flushes++;
`endif
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1; dhit = 0; dREN_mem = 0; dWEN_mem = 0; dREN_ex = 0;
        redirect_ex = 0; halt_ex = 0; Rt_ex = 0; Rs_id = 0; Rt_id = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges (called at posedge+1).
    task automatic do_reset(input string tag);
        #2 nRST = 1'b0;
        #1 check(tag, observed(), 10'd0);
        m_mode = 0; m_left = 0; halted_for = 0;
`ifdef HAZARD_PERF_CNT_EN
        m_stalls = 0; m_flushes = 0;
`endif
        #1 nRST = 1'b1;
    endtask

    initial begin
        int n;
        idle_inputs();
        m_mode = 0; m_left = 0; halted_for = 0;
`ifdef HAZARD_PERF_CNT_EN
        m_stalls = 0; m_flushes = 0;
`endif
        nRST = 1'b0;
        #2 check("reset_outputs", observed(), 10'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b1;
        cyc("run_idle");

        // load-use: one bubble, then free-running
        dREN_ex = 1; Rt_ex = 5'd5; Rs_id = 5'd5; cyc("loaduse_rs");
        dREN_ex = 0; cyc("loaduse_clear");
        dREN_ex = 1; Rt_ex = 5'd7; Rs_id = 5'd1; Rt_id = 5'd7; cyc("loaduse_rt");
        dREN_ex = 1; Rt_ex = 5'd0; Rs_id = 5'd0; Rt_id = 5'd0; cyc("loaduse_r0");
        idle_inputs();

        // dcache miss: three waits then a hit
        dREN_mem = 1; dhit = 0;
        for (int i = 0; i < 3; i++) cyc("dmiss_wait");
        dhit = 1; cyc("dmiss_hit");
        dREN_mem = 0; dhit = 0; cyc("dmiss_after");

        // redirect beats load-use and fetch miss
        dREN_ex = 1; Rt_ex = 5'd3; Rs_id = 5'd3; ihit = 0; redirect_ex = 1;
        cyc("redirect_prio");
        idle_inputs(); ihit = 0; cyc("imiss");
        idle_inputs();
        dWEN_mem = 1; dhit = 1; cyc("store_hit");
        idle_inputs();

        // halt without memory traffic: rises DRAIN+1 cycles after the pulse
        halt_ex = 1; cyc("halt_pulse"); halt_ex = 0;
        n = 1;
        while (halt !== 1'b1 && n < 12) begin cyc("halt_drain"); n++; end
        check("halt_latency", 10'(n), 10'(DRAIN + 1));
        redirect_ex = 1; cyc("halted_sticky1");
        redirect_ex = 0; cyc("halted_sticky2");
        do_reset("reset_halted");
        cyc("run_after_halt_reset");

        // reset in the middle of the drain
        halt_ex = 1; cyc("halt_pulse2"); halt_ex = 0;
        do_reset("reset_mid_drain");
        cyc("run_after_drain_reset");
        cyc("no_halt_after_reset");

        // dcache stall inside the drain delays halt by its length
        halt_ex = 1; cyc("halt_pulse3"); halt_ex = 0;
        dREN_mem = 1; dhit = 0;
        n = 1;
        while (halt !== 1'b1 && n < 14) begin
            if (n == 3) begin dREN_mem = 0; dhit = 1; end
            cyc("halt_drain_stall");
            n++;
        end
        check("halt_latency_stall", 10'(n), 10'(DRAIN + 3));
        idle_inputs();
        do_reset("reset_after_stall_halt");

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            ihit        = ($urandom_range(0, 9) < 8);
            dhit        = ($urandom_range(0, 9) < 5);
            dREN_mem    = ($urandom_range(0, 9) < 2);
            dWEN_mem    = ($urandom_range(0, 9) < 1);
            dREN_ex     = ($urandom_range(0, 9) < 4);
            redirect_ex = ($urandom_range(0, 9) < 2);
            halt_ex     = ($urandom_range(0, 49) == 0);
            Rt_ex       = 5'($urandom_range(0, 3));
            Rs_id       = 5'($urandom_range(0, 3));
            Rt_id       = 5'($urandom_range(0, 3));
            if (halted_for > 2 && $urandom_range(0, 1) == 1) do_reset("rand_reset");
            cyc("random");
        end

`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cycles === CNT_W'(m_stalls)) else begin
            errors++;
            $error("FAIL stall_cycles observed=%0d expected=%0d", stall_cycles, m_stalls);
        end
        checks++;
        assert (flush_events === CNT_W'(m_flushes)) else begin
            errors++;
            $error("FAIL flush_events observed=%0d expected=%0d", flush_events, m_flushes);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
